// File: rtl/pc_unit.sv
// pc_unit: MIPS fetch-stage program counter with start-up stall, buffered redirects and a halt/wrap address limit.
// Optional redirect alignment check is compiled in when PC_ALIGN_CHECK_EN is defined.
module pc_unit #(
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    RESET_ADDR  = '0,
  parameter int unsigned          STEP        = 4,
  parameter int unsigned          START_STALL = 2,
  parameter logic [ADDR_W-1:0]    LIMIT       = ADDR_W'(32'h0000_07FF),
  parameter bit                   WRAP        = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Hold,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Addr,
  output logic [ADDR_W-1:0] PCResult,
  output logic [ADDR_W-1:0] PCPlus,
  output logic              stall,
  output logic              Halted,
  output logic              Redirect_Pending,
  output logic              Misaligned
);

  localparam int unsigned       CNT_W    = (START_STALL > 1) ? $clog2(START_STALL) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((START_STALL == 0) ? 0 : START_STALL - 1);
  localparam logic [ADDR_W:0]   LIM_EXT  = {1'b0, LIMIT};
  localparam logic [ADDR_W:0]   STEP_EXT = (ADDR_W+1)'(STEP);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic                pend_q;
  logic                stall_q;
  logic                halted_q;
  logic                mis_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                bad_redirect;
  logic                live_redirect;
  logic [ADDR_W:0]     seq_sum;
  logic [ADDR_W:0]     pc_cand_d;
  logic                cand_oor;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(STEP - 1);
  assign bad_redirect = Redirect && ((Redirect_Addr & STEP_MASK) != '0);
`else
  assign bad_redirect = 1'b0;
`endif

  assign live_redirect = Redirect & ~bad_redirect;

  // One extra bit so an increment past 2^ADDR_W lands above LIMIT and counts as out of range.
  assign seq_sum = {1'b0, pc_q} + STEP_EXT;

  always_comb begin
    pc_cand_d = seq_sum;
    if (live_redirect) begin
      pc_cand_d = {1'b0, Redirect_Addr};
    end else if (pend_q) begin
      pc_cand_d = {1'b0, pend_addr_q};
    end
  end

  assign cand_oor = (pc_cand_d >= LIM_EXT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= (START_STALL == 0) ? ST_RUN : ST_STARTUP;
      stall_q     <= (START_STALL != 0);
      pc_q        <= RESET_ADDR;
      pend_q      <= 1'b0;
      pend_addr_q <= RESET_ADDR;
      halted_q    <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mis_q <= 1'b0;
      if (Enable) begin
        case (state_q)
          ST_STARTUP: begin
            mis_q <= bad_redirect;
            if (live_redirect) begin
              pend_q      <= 1'b1;
              pend_addr_q <= Redirect_Addr;
            end
            // The PC stays put on the exit cycle; sequential fetch starts on the next one.
            if (cnt_q == LAST_CNT) begin
              state_q <= ST_RUN;
              stall_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            mis_q <= bad_redirect;
            if (Hold) begin
              if (live_redirect) begin
                pend_q      <= 1'b1;
                pend_addr_q <= Redirect_Addr;
              end
            end else begin
              pend_q <= 1'b0;
              if (!cand_oor) begin
                pc_q <= pc_cand_d[ADDR_W-1:0];
              end else if (WRAP) begin
                pc_q <= RESET_ADDR;
              end else begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end
            end
          end
          ST_HALT: begin
          end
          default: begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign PCResult         = pc_q;
  assign PCPlus           = pc_q + ADDR_W'(STEP);
  assign stall            = stall_q;
  assign Halted           = halted_q;
  assign Redirect_Pending = pend_q;
  assign Misaligned       = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomised scoreboard bench for pc_unit: two configurations (halt at default limit, wrap at a low limit)
// driven by shared stimulus and checked against a rule-level reference model.
module tb_pc_unit;

  localparam int M_START = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // Configuration B: no start-up stall, small limit, wraps to a non-zero reset address.
  localparam logic [31:0] B_RESET = 32'h40;
  localparam logic [31:0] B_LIMIT = 32'h100;

  typedef struct {
    int          mode;
    int          cnt;
    logic [31:0] pc;
    bit          pv;
    logic [31:0] pa;
    bit          mis;
  } mstate_t;

  logic        clk;
  logic        rst, en, hold, redir;
  logic [31:0] raddr;

  logic [31:0] pc_a, plus_a, pc_b, plus_b;
  logic        stall_a, halt_a, pend_a, mis_a;
  logic        stall_b, halt_b, pend_b, mis_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mstate_t ma, mb;
  mstate_t qa[$];
  mstate_t qb[$];

  pc_unit dut_a (
    .Clock(clk), .Reset(rst), .Enable(en), .Hold(hold), .Redirect(redir),
    .Redirect_Addr(raddr), .PCResult(pc_a), .PCPlus(plus_a), .stall(stall_a),
    .Halted(halt_a), .Redirect_Pending(pend_a), .Misaligned(mis_a)
  );

  pc_unit #(
    .ADDR_W(32), .RESET_ADDR(B_RESET), .STEP(4), .START_STALL(0),
    .LIMIT(B_LIMIT), .WRAP(1'b1)
  ) dut_b (
    .Clock(clk), .Reset(rst), .Enable(en), .Hold(hold), .Redirect(redir),
    .Redirect_Addr(raddr), .PCResult(pc_b), .PCPlus(plus_b), .stall(stall_b),
    .Halted(halt_b), .Redirect_Pending(pend_b), .Misaligned(mis_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-level model: returns the architectural state after one clock edge.
  function automatic mstate_t model_step(mstate_t s, bit r, bit e, bit h, bit rd,
                                         logic [31:0] ra, int stall_len,
                                         longint limit, bit wrap, logic [31:0] rst_addr);
    mstate_t n;
    bit      bad, live;
    longint  cand;
    n = s;
    n.mis = 1'b0;
    if (r) begin
      n.mode = (stall_len == 0) ? M_RUN : M_START;
      n.cnt  = 0;
      n.pc   = rst_addr;
      n.pv   = 1'b0;
      return n;
    end
    if (!e || s.mode == M_HALT) return n;
    bad   = ALIGN && rd && (ra[1:0] != 2'b00);
    live  = rd && !bad;
    n.mis = bad;
    if (s.mode == M_START || h) begin
      if (live) begin
        n.pv = 1'b1;
        n.pa = ra;
      end
      if (s.mode == M_START) begin
        n.cnt = s.cnt + 1;
        if (n.cnt == stall_len) n.mode = M_RUN;
      end
      return n;
    end
    if (live)      cand = longint'(ra);
    else if (s.pv) cand = longint'(s.pa);
    else           cand = longint'(s.pc) + 4;
    n.pv = 1'b0;
    if (cand < limit) n.pc = cand[31:0];
    else if (wrap)    n.pc = rst_addr;
    else              n.mode = M_HALT;
    return n;
  endfunction

  task automatic drive(bit r, bit e, bit h, bit rd, logic [31:0] ra);
    @(negedge clk);
    rst = r; en = e; hold = h; redir = rd; raddr = ra;
    ma = model_step(ma, r, e, h, rd, ra, 2, 64'h7FF, 1'b0, 32'h0);
    mb = model_step(mb, r, e, h, rd, ra, 0, longint'(B_LIMIT), 1'b1, B_RESET);
    qa.push_back(ma);
    qb.push_back(mb);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0:       a = 32'h7F0 + 32'(4 * $urandom_range(0, 3));
      1:       a = 32'h0F0 + 32'(4 * $urandom_range(0, 3));
      2:       a = 32'($urandom_range(0, 32'h7FF));
      3:       a = 32'h900;
      default: a = 32'($urandom_range(0, 32'h1FF)) << 2;
    endcase
    return a;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: one expected record per edge, compared just after that edge.
  initial begin
    mstate_t ea, eb;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_pc",    pc_a,    ea.pc);
        chk("a_plus",  plus_a,  ea.pc + 32'd4);
        chk("a_stall", 32'(stall_a), 32'(ea.mode == M_START));
        chk("a_halt",  32'(halt_a),  32'(ea.mode == M_HALT));
        chk("a_pend",  32'(pend_a),  32'(ea.pv));
        chk("a_mis",   32'(mis_a),   32'(ea.mis));
        chk("b_pc",    pc_b,    eb.pc);
        chk("b_plus",  plus_b,  eb.pc + 32'd4);
        chk("b_stall", 32'(stall_b), 32'(eb.mode == M_START));
        chk("b_halt",  32'(halt_b),  32'(eb.mode == M_HALT));
        chk("b_pend",  32'(pend_b),  32'(eb.pv));
        chk("b_mis",   32'(mis_b),   32'(eb.mis));
        $display("[TB] cyc %0d A pc=%h st=%0b h=%0b p=%0b | B pc=%h h=%0b p=%0b",
                 cyc, pc_a, stall_a, halt_a, pend_a, pc_b, halt_b, pend_b);
      end
    end
  end

  initial begin
    ma = '{mode: M_RUN, cnt: 0, pc: 32'h0, pv: 1'b0, pa: 32'h0, mis: 1'b0};
    mb = ma;
    rst = 1'b1; en = 1'b0; hold = 1'b0; redir = 1'b0; raddr = '0;

    // Reset, then the start-up stall followed by sequential fetch.
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (5) drive(0, 1, 0, 0, 0);
    // Redirect from 0x10 to 0x40.
    drive(0, 1, 0, 1, 32'h10);
    drive(0, 1, 0, 1, 32'h40);
    drive(0, 1, 0, 0, 0);
    // Hold at 0x20 with two buffered redirects; the newer one wins.
    drive(0, 1, 0, 1, 32'h20);
    drive(0, 1, 1, 1, 32'h80);
    drive(0, 1, 1, 1, 32'h90);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // End of memory: A halts, B wraps; redirect in halt is ignored.
    drive(0, 1, 0, 1, 32'h7FC);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h100);
    drive(0, 1, 1, 1, 32'h104);
    drive(0, 1, 0, 0, 0);
    // B exactly at its limit boundary.
    drive(0, 1, 0, 1, 32'hFC);
    drive(0, 1, 0, 0, 0);
    // Reset out of halt with a redirect pending in startup.
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 32'h60);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Misaligned redirect, then a redirect lost while disabled.
    drive(0, 1, 0, 1, 32'h30);
    drive(0, 1, 0, 1, 32'h42);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h80);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    // Reset while holding with a pending redirect.
    drive(0, 1, 1, 1, 32'h88);
    drive(1, 1, 1, 1, 32'h8C);
    drive(0, 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 3),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            rand_addr());
    end

    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expected records left unchecked, required 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
